// File: rtl/micro_processor_if.sv
// Nibble bus between the stimulus source and the accumulator processor:
// one opcode/operand nibble in, the accumulator value out.
interface micro_processor_if;
  logic [3:0] data_in;
  logic [3:0] accum;

  modport master (output data_in, input accum);
  modport slave  (input data_in, output accum);
endinterface

// File: rtl/micro_processor.sv
// Nibble-serial 4-bit accumulator processor: one nibble per clock, either an
// opcode or the operand of the preceding two-nibble opcode.
module micro_processor (
  input  logic              clk,
  input  logic              reset,
  micro_processor_if.slave  bus
);

  localparam int unsigned W    = 4;
  localparam int unsigned NREG = 4;
  localparam int unsigned RIDX = 2;

  typedef enum logic {
    FETCH,
    OPERAND
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_ANDI = 4'h4,
    OP_ORI  = 4'h5,
    OP_XORI = 4'h6,
    OP_NOT  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_ROL  = 4'hA,
    OP_ROR  = 4'hB,
    OP_INC  = 4'hC,
    OP_DEC  = 4'hD,
    OP_STR  = 4'hE,
    OP_ADDR = 4'hF
  } opcode_t;

  state_t                     state_q, state_d;
  opcode_t                    op_q, op_d;
  logic [W-1:0]               acc_q, acc_d;
  logic [NREG-1:0][W-1:0]     regs_q, regs_d;
  logic [W-1:0]               nib;
  logic [RIDX-1:0]            ridx;
  opcode_t                    nib_op;

  assign nib    = bus.data_in;
  assign ridx   = nib[RIDX-1:0];
  assign nib_op = opcode_t'(bus.data_in);

  // Decode/execute: single-nibble ops act immediately, two-nibble ops wait for the operand
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    regs_d  = regs_q;
    case (state_q)
      FETCH: begin
        case (nib_op)
          OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_STR, OP_ADDR: begin
            op_d    = nib_op;
            state_d = OPERAND;
          end
          OP_NOT:  acc_d = ~acc_q;
          OP_SHL:  acc_d = {acc_q[W-2:0], 1'b0};
          OP_SHR:  acc_d = {1'b0, acc_q[W-1:1]};
          OP_ROL:  acc_d = {acc_q[W-2:0], acc_q[W-1]};
          OP_ROR:  acc_d = {acc_q[0], acc_q[W-1:1]};
          OP_INC:  acc_d = acc_q + W'(1);
          OP_DEC:  acc_d = acc_q - W'(1);
          default: ;
        endcase
      end
      OPERAND: begin
        state_d = FETCH;
        case (op_q)
          OP_LDI:  acc_d = nib;
          OP_ADDI: acc_d = acc_q + nib;
          OP_SUBI: acc_d = acc_q - nib;
          OP_ANDI: acc_d = acc_q & nib;
          OP_ORI:  acc_d = acc_q | nib;
          OP_XORI: acc_d = acc_q ^ nib;
          OP_STR:  regs_d[ridx] = acc_q;
          OP_ADDR: acc_d = acc_q + regs_q[ridx];
          default: ;
        endcase
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset wins over execution and abandons any pending operand
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= OP_NOP;
      acc_q   <= '0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      regs_q  <= regs_d;
    end
  end

  assign bus.accum = acc_q;

endmodule

// File: tb/tb_micro_processor.sv
// Self-checking bench for micro_processor: directed spec sequences plus
// random nibble streams checked against an instruction-level model.
module tb_micro_processor;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  micro_processor_if bus ();

  micro_processor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level model: accumulator, register file, pending two-nibble opcode (-1 = none)
  int m_acc;
  int m_regs [4];
  int m_pend;

  task automatic model_step(input int d, input bit r);
    if (r) begin
      m_acc  = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
      m_pend = -1;
    end else if (m_pend < 0) begin
      case (d)
        1, 2, 3, 4, 5, 6, 14, 15: m_pend = d;
        7:  m_acc = 15 - m_acc;
        8:  m_acc = (m_acc * 2) % 16;
        9:  m_acc = m_acc / 2;
        10: m_acc = (m_acc * 2) % 16 + m_acc / 8;
        11: m_acc = m_acc / 2 + (m_acc % 2) * 8;
        12: m_acc = (m_acc + 1) % 16;
        13: m_acc = (m_acc + 15) % 16;
        default: ;
      endcase
    end else begin
      case (m_pend)
        1:  m_acc = d;
        2:  m_acc = (m_acc + d) % 16;
        3:  m_acc = (m_acc + 16 - d) % 16;
        4:  m_acc = m_acc & d;
        5:  m_acc = m_acc | d;
        6:  m_acc = m_acc ^ d;
        14: m_regs[d % 4] = m_acc;
        15: m_acc = (m_acc + m_regs[d % 4]) % 16;
        default: ;
      endcase
      m_pend = -1;
    end
  endtask

  // Drive one nibble on the falling edge; return 4 ns after the next rising edge
  task automatic send(input logic [3:0] d, input bit r);
    @(negedge clk);
    bus.data_in = d;
    reset       = r;
    model_step(int'(d), r);
    @(posedge clk);
    #4;
  endtask

  // Table entries: {expected accum[11:8], 3'b0, reset[4], data[3:0]}
  task automatic test_reset;
    logic [11:0] v [$];
    v = '{12'h01F, 12'h000};
    foreach (v[i]) begin
      send(v[i][3:0], v[i][4]);
      checks++;
      if (bus.accum !== v[i][11:8]) begin
        errors++;
        $display("FAIL reset step %0d: accum=%h expected=%h", i, bus.accum, v[i][11:8]);
      end
    end
  endtask

  task automatic test_load_arith;
    logic [11:0] v [$];
    v = '{12'h010, 12'h001, 12'h707, 12'h702, 12'h20B, 12'h203, 12'hF03};
    foreach (v[i]) begin
      send(v[i][3:0], v[i][4]);
      checks++;
      if (bus.accum !== v[i][11:8]) begin
        errors++;
        $display("FAIL load_arith step %0d: accum=%h expected=%h", i, bus.accum, v[i][11:8]);
      end
    end
  endtask

  task automatic test_logic_shift;
    logic [11:0] v [$];
    v = '{12'h010, 12'h001, 12'h909, 12'h208, 12'h10B, 12'h20A, 12'hD07,
          12'h609, 12'h606, 12'h90F, 12'h904, 12'h80C, 12'h805, 12'hB03};
    foreach (v[i]) begin
      send(v[i][3:0], v[i][4]);
      checks++;
      if (bus.accum !== v[i][11:8]) begin
        errors++;
        $display("FAIL logic_shift step %0d: accum=%h expected=%h", i, bus.accum, v[i][11:8]);
      end
    end
  endtask

  task automatic test_inc_dec;
    logic [11:0] v [$];
    v = '{12'h010, 12'h001, 12'hF0F, 12'h00C, 12'hF0D};
    foreach (v[i]) begin
      send(v[i][3:0], v[i][4]);
      checks++;
      if (bus.accum !== v[i][11:8]) begin
        errors++;
        $display("FAIL inc_dec step %0d: accum=%h expected=%h", i, bus.accum, v[i][11:8]);
      end
    end
  endtask

  task automatic test_regfile;
    logic [11:0] v [$];
    v = '{12'h010, 12'h001, 12'h505, 12'h50E, 12'h502, 12'h501, 12'h303,
          12'h30F, 12'h806, 12'h80F, 12'h801};
    foreach (v[i]) begin
      send(v[i][3:0], v[i][4]);
      checks++;
      if (bus.accum !== v[i][11:8]) begin
        errors++;
        $display("FAIL regfile step %0d: accum=%h expected=%h", i, bus.accum, v[i][11:8]);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    logic [11:0] v [$];
    v = '{12'h010, 12'h001, 12'h019, 12'h10C, 12'h10C, 12'h206};
    // LDI-less sequence after the abort: INC, then a second INC would be 2; use 2 then XORI pending
    v = '{12'h010, 12'h001, 12'h019, 12'h10C};
    foreach (v[i]) begin
      send(v[i][3:0], v[i][4]);
      checks++;
      if (bus.accum !== v[i][11:8]) begin
        errors++;
        $display("FAIL reset_mid_op step %0d: accum=%h expected=%h", i, bus.accum, v[i][11:8]);
      end
    end
  endtask

  // Random nibble stream with occasional resets, checked against the model
  task automatic test_random(input int n);
    logic [3:0] d;
    bit         r;
    send(4'h0, 1'b1);
    for (int i = 0; i < n; i++) begin
      d = 4'($urandom_range(15, 0));
      r = ($urandom_range(31, 0) == 0);
      send(d, r);
      checks++;
      if (bus.accum !== 4'(m_acc)) begin
        errors++;
        $display("FAIL random step %0d (d=%h r=%0d): accum=%h expected=%h",
                 i, d, r, bus.accum, 4'(m_acc));
      end
    end
  endtask

  // Back-to-back two-nibble ops with no idle cycles between them
  task automatic test_back_to_back(input int n);
    logic [3:0] op;
    logic [3:0] arg;
    send(4'h0, 1'b1);
    for (int i = 0; i < n; i++) begin
      op  = 4'($urandom_range(6, 1));
      arg = 4'($urandom_range(15, 0));
      send(op, 1'b0);
      send(arg, 1'b0);
      checks++;
      if (bus.accum !== 4'(m_acc)) begin
        errors++;
        $display("FAIL back_to_back op=%h n=%h: accum=%h expected=%h",
                 op, arg, bus.accum, 4'(m_acc));
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    bus.data_in = 4'h0;
    m_acc       = 0;
    m_pend      = -1;
    foreach (m_regs[i]) m_regs[i] = 0;

    test_reset();
    test_load_arith();
    test_logic_shift();
    test_inc_dec();
    test_regfile();
    test_reset_mid_op();
    test_back_to_back(40);
    test_random(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
